// File: rtl/axi_mem_slave_pkg.sv
// Shared definitions for the AXI memory responder: response codes, FSM
// state encoding and the byte-lane offset width of a data word.
package axi_mem_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WRESP = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  // Number of byte-offset bits below the word address for a data width.
  function automatic int unsigned bytes_log2(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port RAM with per-byte write enables and a registered read port.
// A read during a write returns the old word (read-first).
module iob_ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Byte-lane writes and a synchronous read; dout holds while en is low.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (we[b]) begin
          mem[addr][b*8 +: 8] <= din[b*8 +: 8];
        end
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave responder over an on-chip byte-enabled RAM. Serves one INCR
// burst at a time (read or write) with round-robin AW/AR arbitration.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The master holds valid and payload until that edge; this block
// holds bvalid/bid/bresp and rvalid/rdata/rid/rlast stable until accepted.
// awready/arready are combinational from the pending valids while IDLE.
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int MEM_ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AXI_ID_W-1:0]     awid,
  input  logic [AXI_ADDR_W-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [AXI_DATA_W-1:0]   wdata,
  input  logic [AXI_DATA_W/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [AXI_ID_W-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [AXI_ID_W-1:0]     arid,
  input  logic [AXI_ADDR_W-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [AXI_ID_W-1:0]     rid,
  output logic [AXI_DATA_W-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [1:0]              dbg_state
);

  localparam int BYTE_LSB = bytes_log2(AXI_DATA_W);
  localparam int STRB_W   = AXI_DATA_W / 8;

  state_t                state_q, state_d;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [8:0]            cnt_q;
  logic [AXI_ID_W-1:0]   id_q;
  logic                  err_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic                  last_write_q;

  logic                  grant_rd;
  logic                  w_hs;
  logic                  r_hs;
  logic                  rd_issue;
  logic                  ram_en;
  logic [STRB_W-1:0]     ram_we;
  logic                  wlast_bad;

  // Address bits outside the RAM word range are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[AXI_ADDR_W-1:MEM_ADDR_W+BYTE_LSB], awaddr[BYTE_LSB-1:0],
                              araddr[AXI_ADDR_W-1:MEM_ADDR_W+BYTE_LSB], araddr[BYTE_LSB-1:0]};

  assign wlast_bad = wlast != (cnt_q == 9'd1);

  // State register; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, arbitration, channel readies and RAM control.
  always_comb begin
    state_d  = state_q;
    awready  = 1'b0;
    arready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    grant_rd = 1'b0;
    w_hs     = 1'b0;
    r_hs     = 1'b0;
    rd_issue = 1'b0;
    ram_en   = 1'b0;
    ram_we   = '0;
    unique case (state_q)
      ST_IDLE: begin
        // Read wins a collision unless the previous grant went to read.
        grant_rd = arvalid & (~awvalid | last_write_q);
        arready  = grant_rd;
        awready  = awvalid & ~grant_rd;
        if (grant_rd) begin
          state_d = ST_READ;
        end else if (awvalid) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wready = 1'b1;
        if (wvalid) begin
          w_hs   = 1'b1;
          ram_en = 1'b1;
          ram_we = wstrb;
          if (cnt_q == 9'd1) begin
            state_d = ST_WRESP;
          end
        end
      end
      ST_WRESP: begin
        bvalid = 1'b1;
        if (bready) begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        r_hs = rvalid_q & rready;
        // Fetch the next word only when the output register is free or draining.
        rd_issue = (cnt_q != 9'd0) & (~rvalid_q | rready);
        ram_en   = rd_issue;
        if (r_hs & rlast_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction capture, burst address/count, write status and R beat flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      last_write_q <= 1'b1;
    end else begin
      if (arready) begin
        addr_q       <= araddr[BYTE_LSB +: MEM_ADDR_W];
        cnt_q        <= {1'b0, arlen} + 9'd1;
        id_q         <= arid;
        last_write_q <= 1'b0;
      end else if (awready) begin
        addr_q       <= awaddr[BYTE_LSB +: MEM_ADDR_W];
        cnt_q        <= {1'b0, awlen} + 9'd1;
        id_q         <= awid;
        err_q        <= 1'b0;
        last_write_q <= 1'b1;
      end
      if (w_hs) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          bresp_q <= (err_q | wlast_bad) ? RESP_SLVERR : RESP_OKAY;
        end else begin
          err_q <= err_q | wlast_bad;
        end
      end
      if (rd_issue) begin
        addr_q   <= addr_q + 1'b1;
        cnt_q    <= cnt_q - 9'd1;
        rvalid_q <= 1'b1;
        rlast_q  <= (cnt_q == 9'd1);
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  iob_ram_sp_be #(
    .DATA_W (AXI_DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (addr_q),
    .din  (wdata),
    .dout (rdata)
  );

  assign bid       = id_q;
  assign bresp     = bresp_q;
  assign rid       = id_q;
  assign rresp     = RESP_OKAY;
  assign rvalid    = rvalid_q;
  assign rlast     = rlast_q;
  assign dbg_state = state_q;

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
AXI4 slave responder backed by an on-chip byte-enabled RAM. It is the far end of the L2 cache's AXI master port. It serves line-fill and write-back bursts in simulation and FPGA builds that have no DDR controller, replacing DDR behind the same AXI port with identical burst semantics. It handles one transaction at a time, in either direction.

Parameters:
AXI_ID_W, 1, width of AXI ID fields
AXI_ADDR_W, 24, AXI byte-address width
AXI_DATA_W, 32, data width; only full-width beats supported
MEM_ADDR_W, 16, RAM depth in words (2^MEM_ADDR_W)

Ports:
clk  in  1  clock
rst  in  1  reset
awid  in  AXI_ID_W  write ID
awaddr  in  AXI_ADDR_W  write start byte address
awlen  in  8  write beats minus 1
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  AXI_DATA_W  write data
wstrb  in  AXI_DATA_W/8  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  AXI_ID_W  response ID
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready
arid  in  AXI_ID_W  read ID
araddr  in  AXI_ADDR_W  read start byte address
arlen  in  8  read beats minus 1
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  AXI_ID_W  read ID
rdata  out  AXI_DATA_W  read data
rresp  out  2  read response (always OKAY)
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready

Behaviour:
- Reset rst is asynchronous and active-high; clock is clk. In reset: state IDLE, and awready, arready, wready, bvalid, rvalid, rlast all 0. bresp, rresp, bid and rid are 0. RAM contents are not reset.
- Reset mid-burst aborts the burst immediately. No B or R beat is issued for the aborted transaction.
- FSM states: IDLE, WRITE, WRESP, READ.
- IDLE, arbitration:
  - awready and arready are combinational and only one is high per cycle.
  - With a single request pending, that request is granted.
  - With both pending, the channel not granted last time wins. The last-grant flag resets to write, so read wins first.
- Transaction capture at AW/AR handshake:
  - Latch ID and beat count (len+1).
  - Word address = addr[MEM_ADDR_W+log2(AXI_DATA_W/8)-1 : log2(AXI_DATA_W/8)]. Low byte-offset bits are ignored.
- Burst addressing: INCR only. The word address increments by 1 per beat and wraps modulo 2^MEM_ADDR_W. Upper address bits are ignored (aliasing).
- WRITE:
  - wready = 1.
  - Each W handshake writes wdata with wstrb byte enables at the current word and decrements the count.
  - After the final counted beat, go to WRESP.
  - If wlast disagrees with the count on any beat (early or missing), latch SLVERR (2'b10); otherwise OKAY (2'b00).
- WRESP: bvalid = 1 with bid and bresp held stable until bready; then return to IDLE.
- READ:
  - RAM read is synchronous, 1-cycle latency. The first rvalid appears 2 cycles after the AR handshake cycle.
  - With rready high, one beat is delivered per cycle.
  - While rvalid & ~rready, rdata, rid and rlast hold stable; the RAM read address does not advance.
  - rlast = 1 only on beat len+1. The handshake on that beat returns to IDLE, and rvalid drops the next cycle unless a new transaction is accepted.
- No AW/AR acceptance outside IDLE, so there is never more than one outstanding transaction.

Decomposition:
- Shared package: RESP_OKAY / RESP_SLVERR constants, FSM state encodings, and log2 of bytes-per-word.
- Sub-module iob_ram_sp_be: single-port RAM with per-byte write enables and synchronous read.

Test Plan:
1. Single beat: AW 0x100 len 0, W 0xDEADBEEF strb 0xF wlast 1 -> B OKAY with matching bid. AR 0x100 len 0 -> R 0xDEADBEEF with rlast=1, rvalid 2 cycles after AR handshake.
2. Line burst: AW 0x40 len 7 with data 0..7, then AR 0x40 len 7 -> 8 consecutive beats 0..7; rlast only on beat 8.
3. Byte strobes: write 0x11223344, then 0xAABBCCDD with strb 4'b0101 -> read returns 0x11BB33DD.
4. Backpressure: 8-beat read with rready toggling every cycle -> sequence 0..7 intact; rdata stable during every stall.
5. Collision and protocol error: awvalid and arvalid together after reset -> read granted first, then write. A write with len 3 and wlast on beat 2 -> bresp 2'b10.
6. Reset mid-read after beat 3 -> rvalid 0 during reset; a following AR 0x40 len 0 returns 0 normally.
